// File: rtl/shift_arbiter_pkg.sv
// rtl/shift_arbiter_pkg.sv - shared op encodings, widths and state types for the shift arbiter.
// Optional build macro SHIFT_ARB_ROTATE_EN turns op 11 into rotate-right.
package shift_arbiter_pkg;

    localparam int SH_W   = 8;
    localparam int SH_SHW = 4;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10,
        SH_ROR = 2'b11
    } sh_op_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/shift_arbiter_core.sv
// rtl/shift_arbiter_core.sv - combinational shift_core: (op, a, shamt) -> result with saturation.
// With SHIFT_ARB_ROTATE_EN defined op 11 rotates right by shamt mod W, otherwise it passes a through.
module shift_core
    import shift_arbiter_pkg::*;
#(
    parameter int W   = SH_W,
    parameter int SHW = SH_SHW
) (
    input  logic [1:0]     op,
    input  logic [W-1:0]   a,
    input  logic [SHW-1:0] shamt,
    output logic [W-1:0]   result
);

    logic saturate;

    assign saturate = (int'(shamt) >= W);

`ifdef SHIFT_ARB_ROTATE_EN
    int             rot_amt;
    logic [2*W-1:0] rot_pair;

    // Shifting a doubled copy keeps the rotate well defined for any rot_amt, including 0.
    always_comb begin
        rot_amt  = int'(shamt) % W;
        rot_pair = {a, a} >> rot_amt;
    end
`endif

    always_comb begin
        result = a;
        case (op)
            SH_SLL: result = saturate ? '0 : (a << shamt);
            SH_SRL: result = saturate ? '0 : (a >> shamt);
            SH_SRA: result = saturate ? {W{a[W-1]}} : W'($signed(a) >>> shamt);
`ifdef SHIFT_ARB_ROTATE_EN
            SH_ROR: result = rot_pair[W-1:0];
`else
            SH_ROR: result = a;
`endif
            default: result = a;
        endcase
    end

endmodule

// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - two-port round-robin arbiter over one shift datapath with a registered result stage.
// Honours SHIFT_ARB_ROTATE_EN through shift_core; the port list is the same in both builds.
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter int W   = SH_W,
    parameter int SHW = SH_SHW
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [1:0]     req0_op,
    input  logic [W-1:0]   req0_a,
    input  logic [SHW-1:0] req0_shamt,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [1:0]     req1_op,
    input  logic [W-1:0]   req1_a,
    input  logic [SHW-1:0] req1_shamt,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [W-1:0]   rsp_data
);

    out_state_e     state;
    logic           last;
    logic           can_accept;
    logic           grant0;
    logic           grant1;
    logic           accept;
    logic           sel;
    logic [1:0]     sel_op;
    logic [W-1:0]   sel_a;
    logic [SHW-1:0] sel_shamt;
    logic [W-1:0]   shift_result;

    // Priority goes to the port that did not win the last accepted handshake.
    always_comb begin
        can_accept = (state == ST_EMPTY) || rsp_ready;
        grant0     = req0_valid && (!req1_valid || last);
        grant1     = req1_valid && (!req0_valid || !last);
        req0_ready = rst_n && grant0 && can_accept;
        req1_ready = rst_n && grant1 && can_accept;
        accept     = req0_ready || req1_ready;
        sel        = req1_ready;
    end

    always_comb begin
        sel_op    = req0_op;
        sel_a     = req0_a;
        sel_shamt = req0_shamt;
        if (sel) begin
            sel_op    = req1_op;
            sel_a     = req1_a;
            sel_shamt = req1_shamt;
        end
    end

    shift_core #(
        .W   (W),
        .SHW (SHW)
    ) u_shift_core (
        .op     (sel_op),
        .a      (sel_a),
        .shamt  (sel_shamt),
        .result (shift_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_EMPTY;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= 1'b0;
            last      <= 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state     <= ST_FULL;
                        rsp_valid <= 1'b1;
                        rsp_data  <= shift_result;
                        rsp_id    <= sel;
                        last      <= sel;
                    end
                end
                ST_FULL: begin
                    // Consume and accept in the same cycle refills without a bubble.
                    if (accept) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= shift_result;
                        rsp_id    <= sel;
                        last      <= sel;
                    end else if (rsp_ready) begin
                        state     <= ST_EMPTY;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - scoreboard bench for shift_arbiter against an arithmetic reference model.
module tb_shift_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0] req0_op, req1_op;
    logic [7:0] req0_a, req1_a;
    logic [3:0] req0_shamt, req1_shamt;
    logic       rsp_valid, rsp_ready, rsp_id;
    logic [7:0] rsp_data;

    typedef struct {
        logic       id;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   m_full, m_last, acc0, acc1;
    bit   can, g0, g1, e0, e1;

    shift_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_shamt (req0_shamt),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_shamt (req1_shamt),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Shift defined as multiplication/division by powers of two on plain integers.
    function automatic logic [7:0] ref_shift(input logic [1:0] op, input logic [7:0] a, input logic [3:0] s);
        int av, n, sv, p, r;
        av = int'(a);
        n  = int'(s);
        case (op)
            2'd0: r = (n >= 8) ? 0 : (av * (1 << n)) % 256;
            2'd1: r = (n >= 8) ? 0 : av / (1 << n);
            2'd2: begin
                sv = (av >= 128) ? av - 256 : av;
                if (n > 8) n = 8;
                p = 1 << n;
                r = (sv >= 0) ? sv / p : -((-sv + p - 1) / p);
            end
            default: begin
`ifdef SHIFT_ARB_ROTATE_EN
                n = n % 8;
                p = 1 << n;
                r = (av / p) + (av % p) * (256 / p);
`else
                r = av;
`endif
            end
        endcase
        return 8'(r & 255);
    endfunction

    // Arbitration model: who should be ready, and what result each handshake must produce.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_full = 1'b0;
            m_last = 1'b1;
            acc0   = 1'b0;
            acc1   = 1'b0;
            check("req0_ready_in_reset", req0_ready, 0);
            check("req1_ready_in_reset", req1_ready, 0);
        end else begin
            can = !m_full || rsp_ready;
            g0  = req0_valid && (!req1_valid || m_last);
            g1  = req1_valid && (!req0_valid || !m_last);
            e0  = g0 && can;
            e1  = g1 && can;
            check("req0_ready", req0_ready, e0);
            check("req1_ready", req1_ready, e1);
            acc0 = e0;
            acc1 = e1;
            if (e0) begin
                q.push_back('{id: 1'b0, data: ref_shift(req0_op, req0_a, req0_shamt), cyc: cyc});
                m_full = 1'b1;
                m_last = 1'b0;
            end else if (e1) begin
                q.push_back('{id: 1'b1, data: ref_shift(req1_op, req1_a, req1_shamt), cyc: cyc});
                m_full = 1'b1;
                m_last = 1'b1;
            end else if (rsp_ready) begin
                m_full = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rsp_unexpected: got rsp_valid=1 data=0x%0h, expected no response", rsp_data);
                end else begin
                    check("rsp_id", rsp_id, q[0].id);
                    check("rsp_data", rsp_data, q[0].data);
                    if (rsp_ready) void'(q.pop_front());
                end
            end else if (q.size() > 0 && q[0].cyc < cyc) begin
                tests++;
                fails++;
                $display("FAIL rsp_missing: got rsp_valid=0, expected data 0x%0h", q[0].data);
                void'(q.pop_front());
            end
        end
    end

    task automatic set_port(input int id, input logic v, input logic [1:0] op, input logic [7:0] a, input logic [3:0] s);
        if (id == 0) begin
            req0_valid = v; req0_op = op; req0_a = a; req0_shamt = s;
        end else begin
            req1_valid = v; req1_op = op; req1_a = a; req1_shamt = s;
        end
    endtask

    task automatic single_op(input int id, input logic [1:0] op, input logic [7:0] a, input logic [3:0] s,
                             input logic [7:0] expv, input string name);
        bit got = 1'b0;
        set_port(id, 1'b1, op, a, s);
        set_port(1 - id, 1'b0, 2'd0, 8'd0, 4'd0);
        rsp_ready = 1'b1;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            #1;
            got = (id == 0) ? acc0 : acc1;
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no acceptance, expected one within 10 cycles", name);
        end else begin
            @(posedge clk);
            #1;
            set_port(id, 1'b0, op, a, s);
            check({name, "_valid"}, rsp_valid, 1);
            check({name, "_id"}, rsp_id, id[0]);
            check({name, "_data"}, rsp_data, expv);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        rsp_ready = 1'b0;
        set_port(0, 1'b1, 2'd0, 8'h11, 4'd1);
        set_port(1, 1'b1, 2'd1, 8'h22, 4'd2);
        repeat (2) @(posedge clk);
        #1;
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_data", rsp_data, 0);
        check("reset_rsp_id", rsp_id, 0);
        check("reset_req0_ready", req0_ready, 0);
        check("reset_req1_ready", req1_ready, 0);
        set_port(0, 1'b0, 2'd0, 8'h00, 4'd0);
        set_port(1, 1'b0, 2'd0, 8'h00, 4'd0);
        rst_n = 1'b1;

        single_op(0, 2'b10, 8'hB4, 4'd2, 8'hED, "sra_first");

        // Both requesters always valid: grants must alternate.
        set_port(0, 1'b1, 2'b00, 8'h01, 4'd3);
        set_port(1, 1'b1, 2'b01, 8'h80, 4'd7);
        rsp_ready = 1'b1;
        repeat (8) begin
            @(posedge clk);
            #1;
        end

        // Back-pressure while FULL: no grants, held result, priority frozen.
        rsp_ready = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end

        single_op(1, 2'b10, 8'h80, 4'd9, 8'hFF, "sra_sat");
        single_op(0, 2'b01, 8'hFF, 4'd8, 8'h00, "srl_sat");
        single_op(1, 2'b00, 8'hFF, 4'd15, 8'h00, "sll_sat");
`ifdef SHIFT_ARB_ROTATE_EN
        single_op(0, 2'b11, 8'h96, 4'd1, 8'h4B, "op11");
        single_op(1, 2'b11, 8'h96, 4'd8, 8'h96, "ror8");
`else
        single_op(0, 2'b11, 8'h96, 4'd1, 8'h96, "op11");
`endif

        // Asynchronous reset while a result is pending.
        rsp_ready = 1'b0;
        set_port(1, 1'b1, 2'b00, 8'h03, 4'd1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #2;
        check("pre_reset_rsp_valid", rsp_valid, 1);
        rst_n = 1'b0;
        #1;
        check("async_reset_rsp_valid", rsp_valid, 0);
        check("async_reset_rsp_data", rsp_data, 0);
        q.delete();
        set_port(0, 1'b1, 2'b01, 8'hF0, 4'd4);
        set_port(1, 1'b1, 2'b00, 8'h0F, 4'd4);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("post_reset_req0_ready", req0_ready, 1);
        check("post_reset_req1_ready", req1_ready, 0);

        // Randomized traffic with random back-pressure and occasional valid drops.
        for (int c = 0; c < 500; c++) begin
            @(posedge clk);
            #1;
            if (acc0 || !req0_valid) begin
                if ($urandom_range(0, 9) < 7)
                    set_port(0, 1'b1, 2'($urandom_range(0, 3)), 8'($urandom), 4'($urandom_range(0, 15)));
                else
                    req0_valid = 1'b0;
            end else if ($urandom_range(0, 19) == 0) begin
                req0_valid = 1'b0;
            end
            if (acc1 || !req1_valid) begin
                if ($urandom_range(0, 9) < 7)
                    set_port(1, 1'b1, 2'($urandom_range(0, 3)), 8'($urandom), 4'($urandom_range(0, 15)));
                else
                    req1_valid = 1'b0;
            end else if ($urandom_range(0, 19) == 0) begin
                req1_valid = 1'b0;
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end

        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("drain_queue_empty", q.size(), 0);
        check("drain_rsp_valid", rsp_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
